// File: rtl/conv_layer_seq.sv
// Time-multiplexed 2-D convolution layer: one MAC per filter per cycle over a
// square image, streaming one output position (all filters) per handshake beat.
module conv_layer_seq #(
    parameter int NUM_FILTERS = 16,
    parameter int IN_SIZE     = 28,
    parameter int FILTER_SIZE = 7,
    parameter int STRIDE      = 2,
    parameter int PIX_W       = 1,
    parameter int W_W         = 32,
    parameter int ACC_W       = 32,
    localparam int OUT_DIM    = (IN_SIZE - FILTER_SIZE) / STRIDE + 1,
    localparam int CW         = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_SIZE*IN_SIZE*PIX_W-1:0]   in_image,
    input  logic [NUM_FILTERS*FILTER_SIZE*FILTER_SIZE*W_W-1:0] in_weights,
    input  logic                               relu_en,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_FILTERS*ACC_W-1:0]       out_data,
    output logic [CW-1:0]                      out_row,
    output logic [CW-1:0]                      out_col,
    output logic                               out_last,
    output logic                               busy
);

    localparam int FS    = FILTER_SIZE;
    localparam int TW    = (FS > 1) ? $clog2(FS) : 1;
    localparam int IMG_W = IN_SIZE * IN_SIZE * PIX_W;
    localparam int WTS_W = NUM_FILTERS * FS * FS * W_W;
    localparam int PW    = PIX_W + 1 + W_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    state_t                       state_q, state_d;
    logic [IMG_W-1:0]             img_q, img_d;
    logic [WTS_W-1:0]             wts_q, wts_d;
    logic                         relu_q, relu_d;
    logic [CW-1:0]                row_q, row_d, col_q, col_d;
    logic [TW-1:0]                ti_q, ti_d, tj_q, tj_d;
    logic [ACC_W-1:0]             acc_q [NUM_FILTERS];
    logic [ACC_W-1:0]             acc_d [NUM_FILTERS];
    logic [NUM_FILTERS*ACC_W-1:0] out_data_q, out_data_d;
    logic [CW-1:0]                out_row_q, out_row_d, out_col_q, out_col_d;
    logic                         out_last_q, out_last_d;

    logic                         accept;
    int                           pix_base;
    logic [PIX_W-1:0]             pix;
    logic [ACC_W-1:0]             prod  [NUM_FILTERS];
    logic [ACC_W-1:0]             sum_w [NUM_FILTERS];

    // Current tap (ti, tj) of the window anchored at (row*STRIDE, col*STRIDE).
    always_comb begin
        pix_base = ((int'(row_q) * STRIDE + int'(ti_q)) * IN_SIZE
                    + int'(col_q) * STRIDE + int'(tj_q)) * PIX_W;
        pix      = PIX_W'(img_q >> pix_base);
    end

    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_mac
        logic [W_W-1:0]       w;
        logic signed [PW-1:0] pa, wb, p;
        assign w  = W_W'(wts_q >> (((f * FS + int'(ti_q)) * FS + int'(tj_q)) * W_W));
        // Pixel is unsigned, so it enters the signed product zero-extended.
        assign pa = {{(W_W + 1){1'b0}}, pix};
        assign wb = {{(PIX_W + 1){w[W_W-1]}}, w};
        assign p  = pa * wb;
        assign prod[f]  = ACC_W'({{ACC_W{p[PW-1]}}, p});
        assign sum_w[f] = acc_q[f] + prod[f];
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign accept    = in_valid && (state_q == ST_IDLE);

    // NOTE: every *_d gets its hold value first so no path through this block
    // leaves a signal unassigned; that is what keeps it free of latches.
    always_comb begin
        state_d    = state_q;
        img_d      = img_q;
        wts_d      = wts_q;
        relu_d     = relu_q;
        row_d      = row_q;
        col_d      = col_q;
        ti_d       = ti_q;
        tj_d       = tj_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        out_last_d = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    img_d  = in_image;
                    wts_d  = in_weights;
                    relu_d = relu_en;
                    row_d  = '0;
                    col_d  = '0;
                    ti_d   = '0;
                    tj_d   = '0;
                    for (int f = 0; f < NUM_FILTERS; f++) acc_d[f] = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                for (int f = 0; f < NUM_FILTERS; f++) acc_d[f] = sum_w[f];
                if (tj_q == TW'(FS - 1)) begin
                    tj_d = '0;
                    if (ti_q == TW'(FS - 1)) begin
                        ti_d = '0;
                        for (int f = 0; f < NUM_FILTERS; f++) begin
                            out_data_d[f*ACC_W +: ACC_W] =
                                (relu_q && sum_w[f][ACC_W-1]) ? '0 : sum_w[f];
                        end
                        out_row_d  = row_q;
                        out_col_d  = col_q;
                        out_last_d = (row_q == CW'(OUT_DIM - 1)) && (col_q == CW'(OUT_DIM - 1));
                        state_d    = ST_OUT;
                    end else begin
                        ti_d = ti_q + TW'(1);
                    end
                end else begin
                    tj_d = tj_q + TW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (col_q == CW'(OUT_DIM - 1)) begin
                            col_d = '0;
                            row_d = row_q + CW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        for (int f = 0; f < NUM_FILTERS; f++) acc_d[f] = '0;
                        state_d = ST_MAC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with <= only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            ti_q       <= '0;
            tj_q       <= '0;
            for (int f = 0; f < NUM_FILTERS; f++) acc_q[f] <= '0;
            out_data_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ti_q       <= ti_d;
            tj_q       <= tj_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_last_q <= out_last_d;
        end
    end

    // NOTE: the wide operand store is not reset: it is always written on
    // accept before any MAC reads it, and a reset net here would be costly.
    always_ff @(posedge clk) begin
        img_q  <= img_d;
        wts_q  <= wts_d;
        relu_q <= relu_d;
    end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: two small instances (stride 1 and 2)
// checked against hand-computed beats, latency, backpressure and reset.
module tb_conv_layer_seq;

    localparam int FS   = 3;
    localparam int A_NF = 2;
    localparam int A_IN = 5;
    localparam int B_NF = 1;
    localparam int B_IN = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                       a_in_valid, a_in_ready, a_relu, a_out_valid, a_out_ready;
    logic [A_IN*A_IN*8-1:0]     a_image;
    logic [A_NF*FS*FS*8-1:0]    a_weights;
    logic [A_NF*8-1:0]          a_out_data;
    logic [1:0]                 a_out_row, a_out_col;
    logic                       a_out_last, a_busy;

    logic                       b_in_valid, b_in_ready, b_relu, b_out_valid, b_out_ready;
    logic [B_IN*B_IN*8-1:0]     b_image;
    logic [B_NF*FS*FS*8-1:0]    b_weights;
    logic [B_NF*8-1:0]          b_out_data;
    logic [1:0]                 b_out_row, b_out_col;
    logic                       b_out_last, b_busy;

    conv_layer_seq #(
        .NUM_FILTERS(A_NF), .IN_SIZE(A_IN), .FILTER_SIZE(FS), .STRIDE(1),
        .PIX_W(8), .W_W(8), .ACC_W(8)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_image(a_image), .in_weights(a_weights), .relu_en(a_relu),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_row(a_out_row), .out_col(a_out_col),
        .out_last(a_out_last), .busy(a_busy)
    );

    conv_layer_seq #(
        .NUM_FILTERS(B_NF), .IN_SIZE(B_IN), .FILTER_SIZE(FS), .STRIDE(2),
        .PIX_W(8), .W_W(8), .ACC_W(8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_image(b_image), .in_weights(b_weights), .relu_en(b_relu),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_row(b_out_row), .out_col(b_out_col),
        .out_last(b_out_last), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] bd   [16];
    logic [1:0]  br   [16];
    logic [1:0]  bc   [16];
    logic        bl   [16];
    int          bcyc [16];
    int          nb;
    logic [15:0] exp_a [9];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [A_IN*A_IN*8-1:0] img,
                           input logic [A_NF*FS*FS*8-1:0] w, input logic relu);
        @(negedge clk);
        check("a_in_ready_idle", a_in_ready, 1);
        a_image    = img;
        a_weights  = w;
        a_relu     = relu;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
    endtask

    // Samples the current point first, then once per falling edge; a beat is
    // recorded wherever valid && ready holds, i.e. it transfers on the next rise.
    task automatic collect(input bit sel_b, input int n, input int bound);
        int cyc;
        nb  = 0;
        cyc = 0;
        while (nb < n && cyc <= bound) begin
            if (!sel_b && a_out_valid && a_out_ready) begin
                bd[nb] = a_out_data; br[nb] = a_out_row; bc[nb] = a_out_col;
                bl[nb] = a_out_last; bcyc[nb] = cyc; nb++;
            end else if (sel_b && b_out_valid && b_out_ready) begin
                bd[nb] = {8'h00, b_out_data}; br[nb] = b_out_row; bc[nb] = b_out_col;
                bl[nb] = b_out_last; bcyc[nb] = cyc; nb++;
            end
            @(negedge clk);
            cyc++;
        end
        check("beat_count", nb, n);
    endtask

    task automatic check_beats(input string tag);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_data%0d", tag, i), bd[i], exp_a[i]);
            check($sformatf("%s_row%0d", tag, i), br[i], i / 3);
            check($sformatf("%s_col%0d", tag, i), bc[i], i % 3);
            check($sformatf("%s_last%0d", tag, i), bl[i], (i == 8));
        end
    endtask

    logic [A_IN*A_IN*8-1:0]  img_ones, img_ff, img_ramp;
    logic [A_NF*FS*FS*8-1:0] w_ones, w_relu, w_ramp;
    logic [B_IN*B_IN*8-1:0]  img_b;
    logic [15:0]             snap_d;
    logic [1:0]              snap_r, snap_c;
    bit                      stable;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        img_ones = {(A_IN*A_IN){8'h01}};
        img_ff   = {(A_IN*A_IN){8'hFF}};
        for (int i = 0; i < A_IN*A_IN; i++) img_ramp[i*8 +: 8] = 8'(i);
        for (int i = 0; i < B_IN*B_IN; i++) img_b[i*8 +: 8] = 8'(i);
        w_ones = {(A_NF*FS*FS){8'h01}};
        w_relu = {{(FS*FS){8'h02}}, {(FS*FS){8'hFF}}};
        w_ramp = {{(FS*FS){8'h01}}, 72'h0};
        w_ramp[4*8 +: 8] = 8'h01;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_relu = 1'b0; a_out_ready = 1'b1; a_image = '0; a_weights = '0;
        b_in_valid = 1'b0; b_relu = 1'b0; b_out_ready = 1'b1; b_image = '0; b_weights = '0;

        // Reset state
        #12;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_row", a_out_row, 0);
        check("rst_out_col", a_out_col, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_b_busy", b_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sum test: every window sums to 9 in both lanes
        start_a(img_ones, w_ones, 1'b0);
        check("sum_busy", a_busy, 1);
        check("sum_in_ready_low", a_in_ready, 0);
        collect(1'b0, 9, 200);
        for (int i = 0; i < 9; i++) exp_a[i] = 16'h0909;
        check_beats("sum");
        // Valid first seen 10 clocks after the accept edge, next beat 10 later
        check("lat_first", bcyc[0], 10);
        check("lat_second", bcyc[1], 20);
        check("sum_in_ready_after", a_in_ready, 1);
        check("sum_busy_after", a_busy, 0);

        // ReLU off / on: filter0 = -9, filter1 = 18
        start_a(img_ones, w_relu, 1'b0);
        collect(1'b0, 9, 200);
        for (int i = 0; i < 9; i++) exp_a[i] = 16'h12F7;
        check_beats("relu_off");
        start_a(img_ones, w_relu, 1'b1);
        collect(1'b0, 9, 200);
        for (int i = 0; i < 9; i++) exp_a[i] = 16'h1200;
        check_beats("relu_on");

        // Wrap: 255 * 1 truncates to -1 per tap, nine taps give 0xF7
        start_a(img_ff, w_ones, 1'b0);
        collect(1'b0, 9, 200);
        for (int i = 0; i < 9; i++) exp_a[i] = 16'hF7F7;
        check_beats("wrap");
        start_a(img_ff, w_ones, 1'b1);
        collect(1'b0, 9, 200);
        for (int i = 0; i < 9; i++) exp_a[i] = 16'h0000;
        check_beats("wrap_relu");

        // Backpressure on beat 1 with a ramp image; inputs scrambled after accept
        a_out_ready = 1'b0;
        start_a(img_ramp, w_ramp, 1'b0);
        a_image   = '0;
        a_weights = '1;
        for (int c = 0; c < 40 && !a_out_valid; c++) @(negedge clk);
        check("bp_valid", a_out_valid, 1);
        snap_d = a_out_data; snap_r = a_out_row; snap_c = a_out_col;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 5) begin
                a_in_valid = 1'b1;
                check("bp_in_ready_low", a_in_ready, 0);
            end
            if (c == 6) a_in_valid = 1'b0;
            if (!a_out_valid || a_out_data !== snap_d || a_out_row !== snap_r ||
                a_out_col !== snap_c) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_held_data", a_out_data, 16'h3606);
        a_out_ready = 1'b1;
        collect(1'b0, 9, 200);
        exp_a = '{16'h3606, 16'h3F07, 16'h4808, 16'h630B, 16'h6C0C,
                  16'h750D, 16'h9010, 16'h9911, 16'hA212};
        check_beats("bp");
        check("bp_idle_after", a_in_ready, 1);

        // Reset during the MAC phase of beat 4
        start_a(img_ones, w_ones, 1'b0);
        collect(1'b0, 3, 200);
        repeat (3) @(negedge clk);
        check("mid_busy_before", a_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_in_ready", a_in_ready, 1);
        check("mid_out_valid", a_out_valid, 0);
        check("mid_busy", a_busy, 0);
        check("mid_out_data", a_out_data, 0);
        check("mid_out_row", a_out_row, 0);
        check("mid_out_col", a_out_col, 0);
        check("mid_out_last", a_out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_a(img_ones, w_relu, 1'b0);
        collect(1'b0, 9, 200);
        for (int i = 0; i < 9; i++) exp_a[i] = 16'h12F7;
        check_beats("post_rst");

        // Stride 2 on a 7x7 ramp, centre tap only: picks pixel(2r+1, 2c+1)
        @(negedge clk);
        check("b_in_ready_idle", b_in_ready, 1);
        b_image   = img_b;
        b_weights = 72'h0;
        b_weights[4*8 +: 8] = 8'h01;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        collect(1'b1, 9, 200);
        exp_a = '{16'd8, 16'd10, 16'd12, 16'd22, 16'd24, 16'd26, 16'd36, 16'd38, 16'd40};
        check_beats("stride");
        check("b_busy_after", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
